// File: rtl/disk_engine_if.sv
// Host-to-disk-engine command and buffer bus. The master is the host front-end,
// the slave is the disk engine.
interface disk_engine_if;
  logic [31:0] instruction;
  logic        write_pause;
  logic        read_pause;
  logic        disk_operate_done;
  logic [8:0]  disk_addr;
  logic        buf_we;
  logic [31:0] host_data_wr;
  logic [31:0] host_data_rd;
  logic        busy;
  logic        err;

  modport master (
    output instruction,
    output write_pause,
    output read_pause,
    output disk_addr,
    output buf_we,
    output host_data_wr,
    input  disk_operate_done,
    input  host_data_rd,
    input  busy,
    input  err
  );

  modport slave (
    input  instruction,
    input  write_pause,
    input  read_pause,
    input  disk_addr,
    input  buf_we,
    input  host_data_wr,
    output disk_operate_done,
    output host_data_rd,
    output busy,
    output err
  );
endinterface

// File: rtl/disk_engine.sv
// Disk engine: 512-word sector buffer plus an on-chip backing store of SECTORS
// sectors. Commands copy one whole sector between buffer and store after a seek
// delay, then pulse disk_operate_done and wait for the pause lines to go quiet.
module disk_engine #(
  parameter int unsigned SECTORS     = 8,
  parameter int unsigned SEEK_CYCLES = 16
) (
  input logic          clk,
  input logic          rst,
  disk_engine_if.slave bus
);

  localparam int unsigned SecW   = $clog2(SECTORS);
  localparam int unsigned SeekW  = (SEEK_CYCLES > 1) ? $clog2(SEEK_CYCLES) : 1;
  localparam int unsigned StoreW = SecW + 9;

  typedef enum logic [2:0] {
    StIdle,
    StSeek,
    StRdCopy,
    StWrCopy,
    StDone,
    StHold
  } state_e;

  state_e           state;
  logic [29:0]      sector;
  logic             is_write;
  logic [SeekW-1:0] seek_cnt;
  logic [9:0]       cnt;
  logic             quiet;
  logic             done;
  logic             busy;
  logic             err;
  logic             host_rd_en;

  logic [31:0] buffer [512];
  logic [31:0] store  [SECTORS*512];
  logic [31:0] buf_rdata;
  logic [31:0] store_rdata;

  logic              wr_accept;
  logic              rd_accept;
  logic              sector_bad;
  logic [8:0]        cnt_prev;
  logic [8:0]        buf_raddr;
  logic [8:0]        buf_waddr;
  logic [31:0]       buf_wdata;
  logic              buf_wen;
  logic [StoreW-1:0] store_raddr;
  logic [StoreW-1:0] store_waddr;
  logic              store_wen;

  // A pause only counts when its direction matches the write flag and the
  // command-select bit is set; write is checked first so it wins ties.
  assign wr_accept  = bus.write_pause & bus.instruction[31] & bus.instruction[30];
  assign rd_accept  = bus.read_pause & ~bus.instruction[31] & bus.instruction[30];
  assign sector_bad = {2'b00, sector} >= SECTORS;
  assign cnt_prev   = cnt[8:0] - 9'd1;

  // Buffer port steering: host owns it in idle, read-copy writes the word
  // returned by the store one cycle after its address was issued.
  always_comb begin
    buf_raddr = (state == StIdle) ? bus.disk_addr : cnt[8:0];
    buf_wen   = 1'b0;
    buf_waddr = bus.disk_addr;
    buf_wdata = bus.host_data_wr;
    if (state == StIdle) begin
      buf_wen = bus.buf_we;
    end else if (state == StRdCopy && cnt != 10'd0) begin
      buf_wen   = 1'b1;
      buf_waddr = cnt_prev;
      buf_wdata = store_rdata;
    end
    // Reset aborts immediately, including the write of the current cycle.
    if (rst) buf_wen = 1'b0;
  end

  // Store port steering: write-copy lands the buffer word read last cycle.
  always_comb begin
    store_raddr = {sector[SecW-1:0], cnt[8:0]};
    store_waddr = {sector[SecW-1:0], cnt_prev};
    store_wen   = !rst && state == StWrCopy && cnt != 10'd0;
  end

  // Sector buffer RAM, read-before-write.
  always_ff @(posedge clk) begin
    if (buf_wen) buffer[buf_waddr] <= buf_wdata;
    buf_rdata <= buffer[buf_raddr];
  end

  // Backing store RAM, read-before-write.
  always_ff @(posedge clk) begin
    if (store_wen) store[store_waddr] <= buf_rdata;
    store_rdata <= store[store_raddr];
  end

  // Command FSM with registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= StIdle;
      sector     <= '0;
      is_write   <= 1'b0;
      seek_cnt   <= '0;
      cnt        <= '0;
      quiet      <= 1'b0;
      done       <= 1'b0;
      busy       <= 1'b0;
      err        <= 1'b0;
      host_rd_en <= 1'b0;
    end else begin
      done       <= 1'b0;
      host_rd_en <= (state == StIdle);
      case (state)
        StIdle: begin
          if (wr_accept || rd_accept) begin
            is_write <= wr_accept;
            sector   <= bus.instruction[29:0];
            busy     <= 1'b1;
            err      <= 1'b0;
            seek_cnt <= '0;
            state    <= StSeek;
          end
        end
        StSeek: begin
          if (sector_bad) begin
            err   <= 1'b1;
            done  <= 1'b1;
            state <= StDone;
          end else if (seek_cnt == SeekW'(SEEK_CYCLES - 1)) begin
            cnt   <= '0;
            state <= is_write ? StWrCopy : StRdCopy;
          end else begin
            seek_cnt <= seek_cnt + 1'b1;
          end
        end
        StRdCopy, StWrCopy: begin
          // 512 issue cycles plus one drain cycle for the pipelined word.
          if (cnt == 10'd512) begin
            done  <= 1'b1;
            state <= StDone;
          end else begin
            cnt <= cnt + 10'd1;
          end
        end
        StDone: begin
          quiet <= 1'b0;
          state <= StHold;
        end
        StHold: begin
          // The front-end keeps toggling pauses while STB is held; wait for
          // two consecutive quiet cycles before accepting anything new.
          if (!bus.write_pause && !bus.read_pause) begin
            if (quiet) begin
              busy  <= 1'b0;
              state <= StIdle;
            end else begin
              quiet <= 1'b1;
            end
          end else begin
            quiet <= 1'b0;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  assign bus.disk_operate_done = done;
  assign bus.busy              = busy;
  assign bus.err               = err;
  assign bus.host_data_rd      = host_rd_en ? buf_rdata : 32'd0;

endmodule

// File: tb/tb_disk_engine.sv
// Directed bench for disk_engine with a scoreboard queue for buffer reads.
module tb_disk_engine;

  logic clk;
  logic rst;
  disk_engine_if bus();

  disk_engine #(
    .SECTORS    (8),
    .SEEK_CYCLES(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %08h want %08h", tag, obs, exp);
    end
  endtask

  // Push the expected word, present the address, pop and compare one cycle on.
  task automatic rd_buf(input logic [8:0] a, input logic [31:0] e);
    logic [31:0] want;
    exp_q.push_back(e);
    bus.disk_addr = a;
    step();
    want = exp_q.pop_front();
    check($sformatf("buf[%0d]", a), bus.host_data_rd, want);
  endtask

  function automatic logic [31:0] pattern(input int mode, input int i);
    case (mode)
      0:       return 32'h100 + 32'(i);
      1:       return 32'hA5A5_0000 ^ 32'(i);
      default: return 32'd0;
    endcase
  endfunction

  task automatic fill(input int mode);
    for (int i = 0; i < 512; i++) begin
      bus.buf_we       = 1'b1;
      bus.disk_addr    = 9'(i);
      bus.host_data_wr = pattern(mode, i);
      step();
    end
    bus.buf_we = 1'b0;
  endtask

  task automatic start_cmd(input logic [31:0] instr, input bit wr);
    bus.instruction = instr;
    bus.write_pause = wr;
    bus.read_pause  = !wr;
    step();
    bus.write_pause = 1'b0;
    bus.read_pause  = 1'b0;
  endtask

  task automatic wait_done(input int n_in, output int n_out);
    n_out = n_in;
    while (bus.disk_operate_done !== 1'b1 && n_out < 2000) begin
      step();
      n_out++;
    end
  endtask

  task automatic finish_cmd(input string tag);
    int k;
    step();
    check({tag, "_done_1cyc"}, 32'(bus.disk_operate_done), 32'd0);
    k = 0;
    while (bus.busy !== 1'b0 && k < 20) begin
      step();
      k++;
    end
    check({tag, "_idle"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int n;
    int dones;

    rst              = 1'b1;
    bus.instruction  = '0;
    bus.write_pause  = 1'b0;
    bus.read_pause   = 1'b0;
    bus.disk_addr    = '0;
    bus.buf_we       = 1'b0;
    bus.host_data_wr = '0;
    repeat (3) step();
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.disk_operate_done), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    check("rst_rd", bus.host_data_rd, 32'd0);
    rst = 1'b0;
    step();

    // Mismatched pauses are ignored.
    bus.instruction = 32'h4000_0003;
    bus.write_pause = 1'b1;
    step();
    bus.write_pause = 1'b0;
    check("ign_wr_flag", 32'(bus.busy), 32'd0);
    bus.instruction = 32'h0000_0003;
    bus.read_pause  = 1'b1;
    step();
    bus.read_pause = 1'b0;
    check("ign_sel", 32'(bus.busy), 32'd0);

    // Buffer write then read back.
    bus.buf_we       = 1'b1;
    bus.disk_addr    = 9'h005;
    bus.host_data_wr = 32'hDEAD_BEEF;
    step();
    bus.buf_we = 1'b0;
    rd_buf(9'h005, 32'hDEAD_BEEF);

    // Write sector 3 from buffer i+0x100.
    fill(0);
    start_cmd(32'hC000_0003, 1'b1);
    check("wr3_busy", 32'(bus.busy), 32'd1);
    wait_done(1, n);
    check("wr3_lat", 32'(n), 32'd530);
    check("wr3_err", 32'(bus.err), 32'd0);
    finish_cmd("wr3");

    // Clear buffer, read sector 3 back.
    fill(2);
    rd_buf(9'd0, 32'd0);
    start_cmd(32'h4000_0003, 1'b0);
    wait_done(1, n);
    check("rd3_lat", 32'(n), 32'd530);
    finish_cmd("rd3");
    rd_buf(9'd0, 32'h100);
    rd_buf(9'd255, 32'h1FF);
    rd_buf(9'd511, 32'h2FF);

    // Sector 0 gets a distinct pattern, then an out-of-range write must not touch it.
    fill(1);
    start_cmd(32'hC000_0000, 1'b1);
    wait_done(1, n);
    check("wr0_lat", 32'(n), 32'd530);
    finish_cmd("wr0");
    fill(0);
    start_cmd(32'hC000_0008, 1'b1);
    wait_done(1, n);
    check("oor_lat", 32'(n), 32'd2);
    check("oor_err", 32'(bus.err), 32'd1);
    finish_cmd("oor");
    check("oor_err_sticky", 32'(bus.err), 32'd1);
    start_cmd(32'h4000_0000, 1'b0);
    check("err_clr", 32'(bus.err), 32'd0);
    wait_done(1, n);
    check("rd0_lat", 32'(n), 32'd530);
    finish_cmd("rd0");
    rd_buf(9'd0, 32'hA5A5_0000);
    rd_buf(9'd8, 32'hA5A5_0008);
    rd_buf(9'd511, 32'hA5A5_01FF);

    // Pause toggling while the front-end holds STB: one command, one pulse.
    dones = 0;
    bus.instruction = 32'hC000_0005;
    for (int i = 0; i < 600; i++) begin
      bus.write_pause = (i % 2 == 0);
      step();
      if (bus.disk_operate_done === 1'b1) dones++;
    end
    bus.write_pause = 1'b0;
    check("tog_dones", 32'(dones), 32'd1);
    check("tog_busy_hold", 32'(bus.busy), 32'd1);
    step();
    check("tog_idle", 32'(bus.busy), 32'd0);

    // Host buffer access is locked out during a read copy.
    start_cmd(32'h4000_0003, 1'b0);
    n = 1;
    while (n < 50) begin
      step();
      n++;
    end
    check("lock_busy", 32'(bus.busy), 32'd1);
    check("lock_rd0", bus.host_data_rd, 32'd0);
    bus.buf_we       = 1'b1;
    bus.disk_addr    = 9'd0;
    bus.host_data_wr = 32'h1234_5678;
    step();
    bus.buf_we = 1'b0;
    n++;
    check("lock_rd1", bus.host_data_rd, 32'd0);
    wait_done(n, n);
    check("lock_lat", 32'(n), 32'd530);
    finish_cmd("lock");
    rd_buf(9'd0, 32'h100);

    // Reset in the middle of a write copy (cnt=200 at cycle 217).
    start_cmd(32'hC000_0001, 1'b1);
    n = 1;
    while (n < 217) begin
      step();
      n++;
    end
    check("mid_busy", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.disk_operate_done), 32'd0);
    check("abort_err", 32'(bus.err), 32'd0);
    start_cmd(32'h4000_0003, 1'b0);
    wait_done(1, n);
    check("post_lat", 32'(n), 32'd530);
    finish_cmd("post");
    rd_buf(9'd0, 32'h100);
    rd_buf(9'd511, 32'h2FF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
